// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracker, load-use stall and operand forwarding.
// Optional perf counters are compiled in when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
  parameter int XLEN           = 64,
  parameter int REG_AW         = 5,
  parameter int PIPE_DEPTH     = 3,
  parameter int LOAD_FWD_STAGE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic                             id_reg_write,
  input  logic                             id_is_load,
  input  logic [REG_AW-1:0]                id_rd,
  input  logic [REG_AW-1:0]                id_rs1_addr,
  input  logic [REG_AW-1:0]                id_rs2_addr,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [XLEN-1:0]                  id_rs1_data,
  input  logic [XLEN-1:0]                  id_rs2_data,
  input  logic [PIPE_DEPTH*XLEN-1:0]       stage_data,
  input  logic                             ext_stall,
  input  logic                             flush,
  output logic                             stall,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]  rs1_fwd_sel,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]  rs2_fwd_sel,
  output logic [XLEN-1:0]                  rs1_val,
  output logic [XLEN-1:0]                  rs2_val
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_fwd_cnt
`endif
);

  localparam int SEL_W = $clog2(PIPE_DEPTH+1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } entry_t;

  entry_t [PIPE_DEPTH-1:0] ent_q;
  entry_t [PIPE_DEPTH-1:0] ent_d;
  entry_t                  id_ent;

  logic [SEL_W-1:0] rs1_sel;
  logic [SEL_W-1:0] rs2_sel;
  logic             rs1_early;
  logic             rs2_early;
  logic             load_hazard;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    rs1_sel   = '0;
    rs2_sel   = '0;
    rs1_early = 1'b0;
    rs2_early = 1'b0;
    for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
      if (id_rs1_used && (id_rs1_addr != '0) &&
          ent_q[k].valid && (ent_q[k].rd == id_rs1_addr)) begin
        rs1_sel   = SEL_W'(k + 1);
        rs1_early = ent_q[k].is_load && (k < LOAD_FWD_STAGE);
      end
      if (id_rs2_used && (id_rs2_addr != '0) &&
          ent_q[k].valid && (ent_q[k].rd == id_rs2_addr)) begin
        rs2_sel   = SEL_W'(k + 1);
        rs2_early = ent_q[k].is_load && (k < LOAD_FWD_STAGE);
      end
    end
  end

  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (rs1_sel == SEL_W'(k + 1)) begin
        rs1_val = stage_data[k*XLEN +: XLEN];
      end
      if (rs2_sel == SEL_W'(k + 1)) begin
        rs2_val = stage_data[k*XLEN +: XLEN];
      end
    end
  end

  assign load_hazard = rs1_early | rs2_early;
  assign stall       = ext_stall | (load_hazard & ~flush);
  assign rs1_fwd_sel = rs1_sel;
  assign rs2_fwd_sel = rs2_sel;

  always_comb begin
    id_ent.valid   = id_valid & id_reg_write & (id_rd != '0);
    id_ent.rd      = id_rd;
    id_ent.is_load = id_is_load;
  end

  // A frozen pipeline holds everything; flush and load-use both inject a bubble.
  always_comb begin
    ent_d = ent_q;
    if (!ext_stall) begin
      ent_d[0] = (flush | load_hazard) ? '0 : id_ent;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ent_d[i] = ent_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (load_hazard & ~flush & ~ext_stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (~stall & ((rs1_sel != '0) | (rs2_sel != '0))) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, corner sequences and
// randomized traffic against a queue-based reference of in-flight writes.
module tb_hazard_scoreboard;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int D    = 3;
  localparam int LFS  = 1;
  localparam int SW   = $clog2(D+1);

  localparam logic [63:0] SD0 = 64'h1234;
  localparam logic [63:0] SD1 = 64'hAAAA;
  localparam logic [63:0] SD2 = 64'hBBBB;
  localparam logic [63:0] RF1 = 64'h1111;
  localparam logic [63:0] RF2 = 64'h2222;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_reg_write, id_is_load;
  logic [AW-1:0]     id_rd, id_rs1_addr, id_rs2_addr;
  logic              id_rs1_used, id_rs2_used;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data;
  logic [D*XLEN-1:0] stage_data;
  logic              ext_stall, flush;
  logic              stall;
  logic [SW-1:0]     rs1_fwd_sel, rs2_fwd_sel;
  logic [XLEN-1:0]   rs1_val, rs2_val;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_fwd_cnt;
  int unsigned       m_stall_cnt, m_fwd_cnt;
`endif

  hazard_scoreboard #(
    .XLEN(XLEN), .REG_AW(AW), .PIPE_DEPTH(D), .LOAD_FWD_STAGE(LFS)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_rd(id_rd),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .stage_data(stage_data), .ext_stall(ext_stall), .flush(flush),
    .stall(stall), .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference: list of in-flight writes, index 0 = youngest (EX).
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } rec_t;
  rec_t mq[$];

  function automatic void mclear();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('{0, 0, 0});
`ifdef HAZARD_SCOREBOARD_PERF_EN
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
`endif
  endfunction

  function automatic int mfind(int addr, bit used);
    if (!used || addr == 0) return -1;
    for (int k = 0; k < D; k++)
      if (mq[k].v && mq[k].rd == addr) return k;
    return -1;
  endfunction

  function automatic bit mhaz();
    int k1 = mfind(int'(id_rs1_addr), id_rs1_used);
    int k2 = mfind(int'(id_rs2_addr), id_rs2_used);
    return (k1 >= 0 && mq[k1].ld && k1 < LFS) ||
           (k2 >= 0 && mq[k2].ld && k2 < LFS);
  endfunction

  function automatic logic [63:0] mval(int k, logic [63:0] rf);
    if (k < 0) return rf;
    return stage_data[k*XLEN +: XLEN];
  endfunction

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic check_model(string tag);
    bit h = mhaz();
    int k1 = mfind(int'(id_rs1_addr), id_rs1_used);
    int k2 = mfind(int'(id_rs2_addr), id_rs2_used);
    check({tag, ".stall"}, 64'(stall), 64'(ext_stall | (h & ~flush)));
    if (!h) begin
      check({tag, ".sel1"}, 64'(rs1_fwd_sel), 64'(k1 + 1));
      check({tag, ".sel2"}, 64'(rs2_fwd_sel), 64'(k2 + 1));
      check({tag, ".val1"}, rs1_val, mval(k1, id_rs1_data));
      check({tag, ".val2"}, rs2_val, mval(k2, id_rs2_data));
    end
  endtask

  task automatic model_step();
    bit h = mhaz();
    bit st = ext_stall | (h & ~flush);
    int k1 = mfind(int'(id_rs1_addr), id_rs1_used);
    int k2 = mfind(int'(id_rs2_addr), id_rs2_used);
    rec_t n;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    if (h && !flush && !ext_stall) m_stall_cnt++;
    if (!st && (k1 >= 0 || k2 >= 0)) m_fwd_cnt++;
`endif
    if (!ext_stall) begin
      if (flush || h) n = '{0, 0, 0};
      else n = '{id_valid && id_reg_write && id_rd != 0, int'(id_rd), id_is_load};
      mq.push_front(n);
      void'(mq.pop_back());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic set_id(bit v, bit rw, bit ld, int rd,
                        int r1, bit u1, int r2, bit u2);
    id_valid     = v;
    id_reg_write = rw;
    id_is_load   = ld;
    id_rd        = AW'(rd);
    id_rs1_addr  = AW'(r1);
    id_rs1_used  = u1;
    id_rs2_addr  = AW'(r2);
    id_rs2_used  = u2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mclear();
    #3;
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  typedef struct {
    bit          v, rw, ld;
    int          rd, r1, r2;
    bit          u1, u2, chk;
    bit          e_st;
    int          e_s1, e_s2;
    logic [63:0] e_v1, e_v2;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1,1,0, 5, 0,0, 0,0, 1, 0, 0,0, RF1,RF2};
    tbl[1] = '{1,1,0, 3, 5,6, 1,1, 1, 0, 1,0, SD0,RF2};
    tbl[2] = '{1,1,1, 7, 5,0, 1,0, 1, 0, 2,0, SD1,RF2};
    tbl[3] = '{1,1,0, 9, 3,7, 1,1, 0, 1, 0,0, 0,0};
    tbl[4] = '{1,1,0, 3, 3,7, 1,1, 1, 0, 3,2, SD2,SD1};
    tbl[5] = '{1,1,0, 4, 0,7, 1,1, 1, 0, 0,3, RF1,SD2};
    tbl[6] = '{1,1,0, 3, 3,4, 1,0, 1, 0, 2,0, SD1,RF2};
    tbl[7] = '{1,1,0, 0, 3,4, 1,1, 1, 0, 1,2, SD0,SD1};
    tbl[8] = '{0,0,0, 0, 0,0, 1,1, 1, 0, 0,0, RF1,RF2};
    tbl[9] = '{0,0,0, 0, 3,3, 0,1, 1, 0, 0,3, RF1,SD2};

    rst         = 1'b0;
    ext_stall   = 1'b0;
    flush       = 1'b0;
    id_rs1_data = RF1;
    id_rs2_data = RF2;
    stage_data  = {SD2, SD1, SD0};
    set_id(0, 0, 0, 0, 3, 1, 4, 1);
    mclear();

    #2;
    check("reset.stall", 64'(stall), 64'd0);
    check("reset.sel1", 64'(rs1_fwd_sel), 64'd0);
    check("reset.val2", rs2_val, RF2);
    #5;
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      set_id(tbl[i].v, tbl[i].rw, tbl[i].ld, tbl[i].rd,
             tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2);
      #4;
      check($sformatf("vec%0d.stall", i), 64'(stall), 64'(tbl[i].e_st));
      if (tbl[i].chk) begin
        check($sformatf("vec%0d.sel1", i), 64'(rs1_fwd_sel), 64'(tbl[i].e_s1));
        check($sformatf("vec%0d.sel2", i), 64'(rs2_fwd_sel), 64'(tbl[i].e_s2));
        check($sformatf("vec%0d.val1", i), rs1_val, tbl[i].e_v1);
        check($sformatf("vec%0d.val2", i), rs2_val, tbl[i].e_v2);
      end
      tick();
    end

    // Flush while a load hazard is pending.
    do_reset();
    set_id(1, 1, 1, 9, 0, 0, 0, 0);
    tick();
    set_id(1, 1, 0, 10, 9, 1, 0, 0);
    flush = 1'b1;
    #4;
    check("flush.stall", 64'(stall), 64'd0);
    tick();
    flush = 1'b0;
    set_id(0, 0, 0, 0, 9, 1, 10, 1);
    #4;
    check("flush.stall2", 64'(stall), 64'd0);
    check("flush.sel_ld", 64'(rs1_fwd_sel), 64'd2);
    check("flush.bubble", 64'(rs2_fwd_sel), 64'd0);
    tick();

    // External freeze holds all entries.
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      set_id(1, 1, 0, r, 0, 0, 0, 0);
      tick();
    end
    ext_stall = 1'b1;
    set_id(1, 1, 0, 5, 1, 1, 3, 1);
    for (int c = 0; c < 3; c++) begin
      #4;
      check("ext.stall", 64'(stall), 64'd1);
      check("ext.sel1", 64'(rs1_fwd_sel), 64'd3);
      check("ext.sel2", 64'(rs2_fwd_sel), 64'd1);
      tick();
    end
    ext_stall = 1'b0;
    set_id(0, 0, 0, 0, 1, 1, 3, 1);
    #4;
    check("ext.rel_stall", 64'(stall), 64'd0);
    check("ext.rel_sel1", 64'(rs1_fwd_sel), 64'd3);
    tick();
    set_id(0, 0, 0, 0, 2, 1, 3, 1);
    #4;
    check("ext.shift_sel1", 64'(rs1_fwd_sel), 64'd3);
    check("ext.shift_sel2", 64'(rs2_fwd_sel), 64'd2);
    tick();

    // Back-to-back dependent loads: one stall per dependent pair.
    do_reset();
    set_id(1, 1, 1, 7, 0, 0, 0, 0);
    tick();
    set_id(1, 1, 1, 8, 7, 1, 0, 0);
    #4;
    check("chain.stall_a", 64'(stall), 64'd1);
    tick();
    #4;
    check("chain.go_a", 64'(stall), 64'd0);
    tick();
    set_id(0, 0, 0, 0, 8, 1, 0, 0);
    #4;
    check("chain.stall_b", 64'(stall), 64'd1);
    tick();
    #4;
    check("chain.go_b", 64'(stall), 64'd0);
    check("chain.sel_b", 64'(rs1_fwd_sel), 64'd2);
    tick();

    // Reset asserted while a load hazard is active.
    do_reset();
    set_id(1, 1, 1, 7, 0, 0, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 7, 1, 7, 1);
    #4;
    check("rstmid.pre", 64'(stall), 64'd1);
    #1;
    rst = 1'b0;
    mclear();
    #1;
    check("rstmid.stall", 64'(stall), 64'd0);
    check("rstmid.sel1", 64'(rs1_fwd_sel), 64'd0);
    check("rstmid.sel2", 64'(rs2_fwd_sel), 64'd0);
    check("rstmid.val1", rs1_val, RF1);
`ifdef HAZARD_SCOREBOARD_PERF_EN
    check("rstmid.pstall", 64'(perf_stall_cnt), 64'd0);
    check("rstmid.pfwd", 64'(perf_fwd_cnt), 64'd0);
`endif
    #1;
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against the reference list.
    for (int n = 0; n < 2000; n++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      ext_stall   = ($urandom_range(0, 7) == 0);
      id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom};
      stage_data  = {$urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom};
      #4;
      check_model($sformatf("rnd%0d", n));
      tick();
    end
`ifdef HAZARD_SCOREBOARD_PERF_EN
    check("perf.stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
    check("perf.fwd_cnt", 64'(perf_fwd_cnt), 64'(m_fwd_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
